// File: rtl/sparce_pkg.sv
// -----------------------------------------------------------------------------
// sparce_pkg
// Shared definitions for the sparce skip unit: SASA table geometry, bit
// positions of the condition word written through the SASA port, the SASA
// entry record, and the skip FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package sparce_pkg;

  localparam int SASA_ENTRIES = 4;
  localparam int NUM_REGS     = 32;

  // Condition word layout (sasa_addr[4] = 1 writes).
  localparam int COND_RS1_LSB     = 0;
  localparam int COND_RS2_LSB     = 5;
  localparam int COND_USE_RS2_BIT = 10;
  localparam int COND_VALID_BIT   = 11;
  localparam int COND_OFFSET_LSB  = 16;

  // Address decode of the SASA write port.
  localparam int ADDR_FIELD_BIT = 4;
  localparam int ADDR_ENTRY_LSB = 2;

  typedef struct packed {
    logic [31:0] tag;
    logic [15:0] offset;   // unsigned byte offset added to the matching pc
    logic        valid;
    logic        use_rs2;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
  } sasa_entry_t;

  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_SKIP  = 2'd1,
    ST_FLUSH = 2'd2
  } sparce_state_t;

  // Replace the condition fields of an entry, keeping its tag.
  function automatic sasa_entry_t apply_cond(input sasa_entry_t e,
                                             input logic [31:0] d);
    sasa_entry_t r;
    r         = e;
    r.rs1     = d[COND_RS1_LSB +: 5];
    r.rs2     = d[COND_RS2_LSB +: 5];
    r.use_rs2 = d[COND_USE_RS2_BIT];
    r.valid   = d[COND_VALID_BIT];
    r.offset  = d[COND_OFFSET_LSB +: 16];
    return r;
  endfunction

endpackage

// File: rtl/sparce_skip_unit_if.sv
// -----------------------------------------------------------------------------
// sparce_skip_unit_if
// Pipeline <-> sparce interface.
//   pc, is_sparse              : lookup request
//   wb_en, wb_rd, wb_data      : register writeback snoop
//   sasa_wen, sasa_addr, sasa_data : SASA table write port
//   sparce_target, skipping    : fetch redirect back to the pipeline
// Modports: master = pipeline side, slave = sparce side.
//
// Handshake: there is no backpressure anywhere. is_sparse qualifies pc for
// the cycle it is high; wb_en and sasa_wen are single-cycle write strobes
// that are always accepted (except while RST is high). skipping is a
// one-cycle strobe and sparce_target is only meaningful while it is high.
// -----------------------------------------------------------------------------
interface sparce_skip_unit_if;
  logic [31:0] pc;
  logic        is_sparse;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        sasa_wen;
  logic [31:0] sasa_addr;
  logic [31:0] sasa_data;
  logic [31:0] sparce_target;
  logic        skipping;

  modport master (
    output pc, is_sparse, wb_en, wb_rd, wb_data, sasa_wen, sasa_addr, sasa_data,
    input  sparce_target, skipping
  );

  modport slave (
    input  pc, is_sparse, wb_en, wb_rd, wb_data, sasa_wen, sasa_addr, sasa_data,
    output sparce_target, skipping
  );
endinterface

// File: rtl/sparce_sprf.sv
// -----------------------------------------------------------------------------
// sparce_sprf
// Sparsity register file: one bit per architectural register, 1 = register
// currently holds zero. x0 always reads 1. Read ports are combinational and
// see a same-cycle writeback (write-through bypass).
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   wb_en, wb_rd, wb_data  writeback snoop (write port)
//   rd_addr[N_RD]       read addresses
//   rd_zero[N_RD]       sparsity bit for each read address
// -----------------------------------------------------------------------------
module sparce_sprf
  import sparce_pkg::*;
#(
  parameter int N_RD = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 wb_en,
  input  logic [4:0]           wb_rd,
  input  logic [31:0]          wb_data,
  input  logic [N_RD-1:0][4:0] rd_addr,
  output logic [N_RD-1:0]      rd_zero
);

  logic [NUM_REGS-1:0] sprf_q;
  logic                wr_active;
  logic                wr_zero;

  // Writes to x0 are ignored so bit 0 never leaves its reset value of 1.
  assign wr_active = wb_en && (wb_rd != 5'd0);
  assign wr_zero   = (wb_data == 32'd0);

  // Reset is conservative: nothing but x0 is known to be zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sprf_q <= {{(NUM_REGS-1){1'b0}}, 1'b1};
    end else if (wr_active) begin
      sprf_q[wb_rd] <= wr_zero;
    end
  end

  always_comb begin
    rd_zero = '0;
    for (int i = 0; i < N_RD; i++) begin
      rd_zero[i] = sprf_q[rd_addr[i]];
      if (wr_active && (wb_rd == rd_addr[i])) begin
        rd_zero[i] = wr_zero;
      end
      if (rd_addr[i] == 5'd0) begin
        rd_zero[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sparce_skip_unit.sv
// -----------------------------------------------------------------------------
// sparce_skip_unit
// Looks up the fetch pc in a small SASA table. An entry hits when its tag
// matches pc and its source registers are known to be zero; the unit then
// raises skipping for one cycle with sparce_target = pc + offset, and holds
// off further lookups for two cycles (SKIP, FLUSH) while fetch redirects.
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   bus        sparce_skip_unit_if.slave (lookup, writeback snoop, SASA
//              write port, redirect outputs)
//   dbg_state  current FSM state
// -----------------------------------------------------------------------------
module sparce_skip_unit
  import sparce_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  sparce_skip_unit_if.slave   bus,
  output sparce_state_t       dbg_state
);

  localparam int N_RD = 2 * SASA_ENTRIES;

  sasa_entry_t            sasa_q [SASA_ENTRIES];
  logic [N_RD-1:0][4:0]   rd_addr;
  logic [N_RD-1:0]        rd_zero;
  logic [SASA_ENTRIES-1:0] hit;
  logic                   hit_any;
  logic [15:0]            hit_offset;
  logic [31:0]            target_next;
  logic [31:0]            target_q;
  logic                   load_target;
  sparce_state_t          state_q;
  sparce_state_t          state_d;
  logic [1:0]             wr_entry;

  assign wr_entry = bus.sasa_addr[ADDR_ENTRY_LSB +: 2];

  // SASA table. Only the valid bits need a reset; tag/conditions of an
  // invalid entry are never looked at. A write lands at the clock edge, so
  // a lookup in the same cycle still sees the old contents.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SASA_ENTRIES; i++) begin
        sasa_q[i].valid <= 1'b0;
      end
    end else if (bus.sasa_wen) begin
      for (int i = 0; i < SASA_ENTRIES; i++) begin
        if (wr_entry == 2'(i)) begin
          if (bus.sasa_addr[ADDR_FIELD_BIT]) begin
            sasa_q[i] <= apply_cond(sasa_q[i], bus.sasa_data);
          end else begin
            sasa_q[i].tag <= bus.sasa_data;
          end
        end
      end
    end
  end

  // Two SpRF read ports per entry: port 2i for rs1, port 2i+1 for rs2.
  always_comb begin
    rd_addr = '0;
    for (int i = 0; i < SASA_ENTRIES; i++) begin
      rd_addr[2*i]   = sasa_q[i].rs1;
      rd_addr[2*i+1] = sasa_q[i].rs2;
    end
  end

  sparce_sprf #(
    .N_RD (N_RD)
  ) u_sprf (
    .CLK     (CLK),
    .RST     (RST),
    .wb_en   (bus.wb_en),
    .wb_rd   (bus.wb_rd),
    .wb_data (bus.wb_data),
    .rd_addr (rd_addr),
    .rd_zero (rd_zero)
  );

  always_comb begin
    hit = '0;
    for (int i = 0; i < SASA_ENTRIES; i++) begin
      hit[i] = bus.is_sparse && sasa_q[i].valid && (sasa_q[i].tag == bus.pc) &&
               rd_zero[2*i] && (!sasa_q[i].use_rs2 || rd_zero[2*i+1]);
    end
  end

  // Priority encoder: scan from the top so the lowest-indexed hit is the
  // last one assigned and therefore wins.
  always_comb begin
    hit_any    = 1'b0;
    hit_offset = '0;
    for (int i = SASA_ENTRIES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any    = 1'b1;
        hit_offset = sasa_q[i].offset;
      end
    end
  end

  // Wraps modulo 2^32 by truncation.
  assign target_next = bus.pc + {16'd0, hit_offset};

  always_comb begin
    state_d     = state_q;
    load_target = 1'b0;
    case (state_q)
      ST_ARMED: begin
        if (hit_any) begin
          state_d     = ST_SKIP;
          load_target = 1'b1;
        end
      end
      ST_SKIP:  state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_ARMED;
      default:  state_d = ST_ARMED;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_ARMED;
      target_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (load_target) begin
        target_q <= target_next;
      end
    end
  end

  assign bus.skipping      = (state_q == ST_SKIP);
  assign bus.sparce_target = target_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_sparce_skip_unit.sv
// -----------------------------------------------------------------------------
// tb_sparce_skip_unit
// Directed bench for sparce_skip_unit. Each step() drives one cycle of
// inputs and pushes the outputs expected during that cycle (which reflect
// the previous cycle's inputs); a monitor pops and compares on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_sparce_skip_unit;
  import sparce_pkg::*;

  logic          CLK;
  logic          RST;
  sparce_state_t dbg_state;

  sparce_skip_unit_if bus ();

  sparce_skip_unit dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  // {check_target, skipping, sparce_target}
  logic [33:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always @(negedge CLK) begin
    logic [33:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (bus.skipping !== e[32]) begin
        n_fail++;
        $display("FAIL skipping @%0t: got %b expected %b", $time, bus.skipping, e[32]);
      end
      if (e[33]) begin
        n_checks++;
        if (bus.sparce_target !== e[31:0]) begin
          n_fail++;
          $display("FAIL sparce_target @%0t: got %h expected %h",
                   $time, bus.sparce_target, e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] cond(input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic use2, input logic valid,
                                       input logic [15:0] off);
    return {off, 4'b0000, valid, use2, rs2, rs1};
  endfunction

  task automatic idle_inputs();
    bus.pc        = 32'd0;
    bus.is_sparse = 1'b0;
    bus.wb_en     = 1'b0;
    bus.wb_rd     = 5'd0;
    bus.wb_data   = 32'd0;
    bus.sasa_wen  = 1'b0;
    bus.sasa_addr = 32'd0;
    bus.sasa_data = 32'd0;
    RST           = 1'b0;
  endtask

  task automatic set_look(input logic [31:0] pc);
    bus.pc        = pc;
    bus.is_sparse = 1'b1;
  endtask

  task automatic set_wb(input logic [4:0] rd, input logic [31:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_rd   = rd;
    bus.wb_data = data;
  endtask

  task automatic set_sasa(input int entry, input logic field, input logic [31:0] data);
    bus.sasa_wen  = 1'b1;
    bus.sasa_addr = {27'd0, field, 2'(entry), 2'b00};
    bus.sasa_data = data;
  endtask

  // Push the outputs expected during the current cycle, then advance.
  task automatic step(input logic chk_tgt, input logic skip, input logic [31:0] tgt);
    exp_q.push_back({chk_tgt, skip, tgt});
    @(posedge CLK);
    #1;
    idle_inputs();
  endtask

  task automatic quiet(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;

    // Reset state
    step(1, 0, 32'h0);

    // Basic skip: entry0 tag 0x100, rs1=x5, offset 0x20; x5 = 0
    set_sasa(0, 0, 32'h100);                       step(0, 0, 0);
    set_sasa(0, 1, cond(5, 0, 0, 1, 16'h20));      step(0, 0, 0);
    set_wb(5, 32'd0);                              step(0, 0, 0);
    set_look(32'h100);                             step(0, 0, 0);
    step(1, 1, 32'h120);
    step(1, 0, 32'h120);                           // target holds
    step(1, 0, 32'h120);

    // x5 non-zero misses; same-cycle writeback of zero is bypassed
    set_wb(5, 32'd7);                              step(0, 0, 0);
    set_look(32'h100);                             step(0, 0, 0);
    set_look(32'h100); set_wb(5, 32'd0);           step(0, 0, 0);
    step(1, 1, 32'h120);
    quiet(2);

    // Same-cycle SASA invalidate: lookup still uses old contents
    set_look(32'h100); set_sasa(0, 1, cond(5, 0, 0, 0, 16'h20)); step(0, 0, 0);
    step(1, 1, 32'h120);
    quiet(2);
    set_look(32'h100);                             step(0, 0, 0);
    step(0, 0, 0);                                 // now misses

    // Priority: entries 1 and 3 both tag 0x200
    set_sasa(1, 0, 32'h200);                       step(0, 0, 0);
    set_sasa(1, 1, cond(5, 0, 1, 1, 16'h8));       step(0, 0, 0);
    set_sasa(3, 0, 32'h200);                       step(0, 0, 0);
    set_sasa(3, 1, cond(0, 0, 0, 1, 16'h40));      step(0, 0, 0);
    set_look(32'h200);                             step(0, 0, 0);
    step(1, 1, 32'h208);
    quiet(2);

    // x0 stays sparse despite a non-zero write; entry 3 wins once 1 is gone
    set_wb(0, 32'd5);                              step(0, 0, 0);
    set_sasa(1, 1, cond(5, 0, 1, 0, 16'h8));       step(0, 0, 0);
    set_look(32'h200);                             step(0, 0, 0);
    step(1, 1, 32'h240);
    quiet(2);

    // use_rs2: entry2 needs x5 and x6 both zero
    set_sasa(2, 0, 32'h300);                       step(0, 0, 0);
    set_sasa(2, 1, cond(5, 6, 1, 1, 16'h10));      step(0, 0, 0);
    set_wb(6, 32'd3);                              step(0, 0, 0);
    set_look(32'h300);                             step(0, 0, 0);
    step(0, 0, 0);                                 // rs2 not sparse
    set_wb(6, 32'd0);                              step(0, 0, 0);
    set_look(32'h300);                             step(0, 0, 0);
    step(1, 1, 32'h310);
    quiet(2);

    // Target wraps modulo 2^32
    set_sasa(0, 0, 32'hFFFF_FFF0);                 step(0, 0, 0);
    set_sasa(0, 1, cond(0, 0, 0, 1, 16'h20));      step(0, 0, 0);
    set_look(32'hFFFF_FFF0);                       step(0, 0, 0);
    step(1, 1, 32'h0000_0010);
    quiet(2);

    // Continuous lookup: 1,0,0,1 then reset during SKIP
    set_sasa(0, 0, 32'h100);                       step(0, 0, 0);
    set_sasa(0, 1, cond(5, 0, 0, 1, 16'h20));      step(0, 0, 0);
    set_look(32'h100);                             step(0, 0, 0);
    set_look(32'h100);                             step(1, 1, 32'h120);
    set_look(32'h100);                             step(0, 0, 0);
    set_look(32'h100);                             step(0, 0, 0);
    // RST while skipping; the SASA write in this cycle must be dropped
    RST = 1'b1; set_look(32'h100); set_wb(5, 32'd0);
    set_sasa(0, 1, cond(0, 0, 0, 1, 16'h20));      step(1, 1, 32'h120);
    set_look(32'h100);                             step(1, 0, 32'h0);
    set_look(32'h100);                             step(1, 0, 32'h0);  // miss
    step(1, 0, 32'h0);                                                 // miss

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge CLK);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sparce_skip_unit.md
SPARCE_SKIP_UNIT -- requirements
Module: sparce_skip_unit

Interface
REQ-001 The block SHALL be clocked by CLK only; RST is synchronous and active-high.
REQ-002 Ports, name / direction / width / meaning:
  CLK            in   1   clock
  RST            in   1   sync active-high reset
  pc             in   32  fetch PC under lookup
  is_sparse      in   1   lookup qualifier; pc valid this cycle
  wb_en          in   1   register writeback strobe
  wb_rd          in   5   writeback destination register
  wb_data        in   32  writeback value
  sasa_wen       in   1   SASA table write strobe
  sasa_addr      in   32  SASA write address; [4] field select, [3:2] entry
  sasa_data      in   32  SASA write data
  sparce_target  out  32  skip destination PC
  skipping       out  1   redirect fetch to sparce_target this cycle
REQ-003 The block SHALL implement the sparce side of the sparce/pipeline interface: it drives sparce_target and skipping; all other interface signals are inputs.

Function
REQ-004 The sparsity register file (SpRF) SHALL hold one bit per architectural register; bit=1 means the register currently holds zero.
REQ-005 On wb_en, SpRF[wb_rd] SHALL be set to (wb_data == 0) at the clock edge; SpRF[0] SHALL read 1 always, and writes to it are ignored.
REQ-006 SASA table: 4 entries, each holding tag (32b) and condition fields rs1[4:0], rs2[9:5], use_rs2[10], valid[11], offset[31:16] (unsigned bytes).
REQ-007 On sasa_wen, the entry at sasa_addr[3:2] SHALL be written: sasa_addr[4]=0 writes tag=sasa_data; sasa_addr[4]=1 writes the condition fields.
REQ-008 Lookup hit: is_sparse=1, entry valid, tag==pc, SpRF[rs1]=1, and (use_rs2=0 or SpRF[rs2]=1).
REQ-009 On multiple hits the lowest-indexed entry SHALL win.
REQ-010 Sparsity used in a lookup SHALL include a same-cycle wb_en write (write-through bypass); SASA contents used SHALL be pre-write (a same-cycle sasa_wen takes effect next cycle).
REQ-011 sparce_target SHALL be (pc + offset) mod 2^32, registered; latency from pc/is_sparse to skipping is exactly 1 cycle.
REQ-012 FSM states ARMED, SKIP, FLUSH: ARMED -> SKIP on hit; SKIP -> FLUSH unconditionally; FLUSH -> ARMED unconditionally; lookups are ignored in SKIP and FLUSH.
REQ-013 skipping SHALL be 1 only in state SKIP, for exactly one cycle per skip; back-to-back skips are separated by at least 2 cycles.
REQ-014 sparce_target SHALL hold its value when not in SKIP; it is only meaningful while skipping=1.
REQ-015 SpRF and SASA writes SHALL proceed in every FSM state.

Reset
REQ-016 On RST: FSM=ARMED, skipping=0, sparce_target=0, all SASA valid bits=0, SpRF=all 0 except bit 0 (conservative: nothing known sparse).
REQ-017 RST asserted while in SKIP or FLUSH SHALL abort the skip; skipping=0 in the cycle after RST is sampled.
REQ-018 Writes presented in the same cycle as RST SHALL be dropped.

Structure
REQ-019 Shared package sparce_pkg SHALL hold SASA_ENTRIES=4, the condition-field bit positions, sasa_entry_t struct, and the FSM state enum.
REQ-020 The SpRF with bypass read ports SHALL be a sub-module sparce_sprf (write port, two combinational read ports per entry lookup path, x0 hardwired).
REQ-021 Target adder and hit priority encoder SHALL remain in sparce_skip_unit.

Verification
REQ-022 Program entry0 tag=0x100, rs1=5, use_rs2=0, offset=0x20, valid; write x5=0; pc=0x100, is_sparse=1 -> next cycle skipping=1, sparce_target=0x120, then 2 cycles skipping=0.
REQ-023 Same setup but x5=7 -> skipping stays 0; then same cycle wb_en x5=0 with pc=0x100 -> bypass hit, skipping=1 next cycle.
REQ-024 Entries 1 and 3 both tag=0x200, offsets 0x8 and 0x40, conditions met -> sparce_target=0x208.
REQ-025 Tag=0xFFFFFFF0, offset=0x20 -> sparce_target=0x00000010 (wrap).
REQ-026 Hit on consecutive cycles pc=0x100 x3 -> skipping pattern 1,0,0,1; RST during SKIP -> skipping=0 next cycle, all valid cleared, re-lookup misses.
